// File: rtl/ftps_axil_reg_slave.sv
// AXI4-Lite register responder for the fingertip upload path: four 32-bit registers,
// per-register write pulses. Define FTPS_AXIL_DECERR_EN to answer 0x10-0x1C with SLVERR.
module ftps_axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]                    wr_pulse_o
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [C_S_AXI_DATA_WIDTH-1:0]   r_regs [NUM_REGS];
    logic                            r_aw_held, r_w_held;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   r_aw_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] r_wstrb;
    logic                            r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]                      r_bresp, r_rresp;
    logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
    logic [NUM_REGS-1:0]             r_wr_pulse;

    logic       w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_b_stall, w_r_stall;
    logic       w_wr_oor, w_rd_oor;
    logic [1:0] w_wr_idx, w_rd_idx;
    logic       w_unused;

    assign w_aw_hs   = S_AXI_AWVALID && r_awready;
    assign w_w_hs    = S_AXI_WVALID && r_wready;
    assign w_ar_hs   = S_AXI_ARVALID && r_arready;
    assign w_commit  = r_aw_held && r_w_held;
    assign w_b_stall = r_bvalid && !S_AXI_BREADY;
    assign w_r_stall = r_rvalid && !S_AXI_RREADY;
    assign w_wr_idx  = r_aw_addr[3:2];
    assign w_rd_idx  = S_AXI_ARADDR[3:2];

`ifdef FTPS_AXIL_DECERR_EN
    assign w_wr_oor = r_aw_addr[4];
    assign w_rd_oor = S_AXI_ARADDR[4];
`else
    assign w_wr_oor = 1'b0;
    assign w_rd_oor = 1'b0;
`endif

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, r_aw_addr[1:0], r_aw_addr[4],
                        S_AXI_ARADDR[1:0], S_AXI_ARADDR[4]};

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_addr  <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            // Ready is registered, so it reflects next cycle's held/BVALID state.
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
                if (!w_wr_oor) begin
                    r_wr_pulse[w_wr_idx] <= 1'b1;
                    for (int k = 0; k < C_S_AXI_DATA_WIDTH/8; k++)
                        if (r_wstrb[k]) r_regs[w_wr_idx][8*k +: 8] <= r_wdata[8*k +: 8];
                end
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_aw_addr <= S_AXI_AWADDR;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= S_AXI_WDATA;
                    r_wstrb  <= S_AXI_WSTRB;
                end
                if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;
            end
            r_awready <= !w_commit && !(r_aw_held || w_aw_hs) && !w_b_stall;
            r_wready  <= !w_commit && !(r_w_held || w_w_hs) && !w_b_stall;

            // Read samples r_regs before any same-edge commit lands.
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_oor ? '0 : r_regs[w_rd_idx];
                r_rresp  <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end
            r_arready <= !(w_ar_hs || w_r_stall);
        end
    end

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_wready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = r_bresp;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = r_rresp;
    assign wr_pulse_o    = r_wr_pulse;

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_regs_out
            assign regs_o[g*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = r_regs[g];
        end
    endgenerate
endmodule

// File: tb/tb_ftps_axil_reg_slave.sv
// Self-checking bench for ftps_axil_reg_slave: vector table, corner sequences, random ops vs model.
module tb_ftps_axil_reg_slave;
    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [4:0]   S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]   S_AXI_AWPROT, S_AXI_ARPROT;
    logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0]  S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
    logic         S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic         S_AXI_RVALID, S_AXI_RREADY;
    logic [127:0] regs_o;
    logic [3:0]   wr_pulse_o;

    ftps_axil_reg_slave dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    always #5 ACLK = ~ACLK;

`ifdef FTPS_AXIL_DECERR_EN
    localparam bit DECERR = 1'b1;
`else
    localparam bit DECERR = 1'b0;
`endif
    localparam logic [1:0]  OOR_RESP = DECERR ? 2'b10 : 2'b00;
    localparam logic [31:0] OOR_RD   = DECERR ? 32'h0 : 32'h55;
    localparam logic [31:0] R1_AFTER = DECERR ? 32'hFF00FF00 : 32'h55;
    localparam int LIM = 50;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        errors++;
        $display("FAIL %s: timed out after %0d cycles", name, LIM);
    endtask

    // Reference model: a four-word memory; upper window either aliases or is rejected.
    function automatic bit oor(input logic [4:0] a);
        return DECERR && (a >= 5'h10);
    endfunction

    function automatic void mdl_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        if (oor(a)) return;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) mask = mask + (32'hFF << (8 * b));
        mdl[(a / 4) % 4] = (mdl[(a / 4) % 4] & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] mdl_read(input logic [4:0] a);
        return oor(a) ? 32'h0 : mdl[(a / 4) % 4];
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int n;
        bit aw_hs, w_hs;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
        S_AXI_BREADY = 1'b1;
        resp = 2'bxx;
        n = 0;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < LIM) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            tick();
            if (aw_hs) S_AXI_AWVALID = 1'b0;
            if (w_hs)  S_AXI_WVALID  = 1'b0;
            n++;
        end
        while (!S_AXI_BVALID && n < LIM) begin tick(); n++; end
        if (n >= LIM) begin
            timeout("write_handshake");
            S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        end else begin
            resp = S_AXI_BRESP;
            tick();
        end
    endtask

    task automatic do_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        bit ar_hs;
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        d = 'x; resp = 2'bxx;
        n = 0;
        while (S_AXI_ARVALID && n < LIM) begin
            ar_hs = S_AXI_ARREADY;
            tick();
            if (ar_hs) S_AXI_ARVALID = 1'b0;
            n++;
        end
        while (!S_AXI_RVALID && n < LIM) begin tick(); n++; end
        if (n >= LIM) begin
            timeout("read_handshake");
            S_AXI_ARVALID = 1'b0;
        end else begin
            d = S_AXI_RDATA; resp = S_AXI_RRESP;
            tick();
        end
    endtask

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [31:0] rd, held;
        logic [1:0]  rsp;
        int n;

        tbl[0]  = '{1'b1, 5'h00, 32'h1,        4'hF, 32'h0,        2'b00};
        tbl[1]  = '{1'b1, 5'h04, 32'h2,        4'hF, 32'h0,        2'b00};
        tbl[2]  = '{1'b1, 5'h08, 32'h3,        4'hF, 32'h0,        2'b00};
        tbl[3]  = '{1'b1, 5'h0C, 32'h4,        4'hF, 32'h0,        2'b00};
        tbl[4]  = '{1'b0, 5'h00, 32'h0,        4'h0, 32'h1,        2'b00};
        tbl[5]  = '{1'b0, 5'h04, 32'h0,        4'h0, 32'h2,        2'b00};
        tbl[6]  = '{1'b0, 5'h08, 32'h0,        4'h0, 32'h3,        2'b00};
        tbl[7]  = '{1'b0, 5'h0C, 32'h0,        4'h0, 32'h4,        2'b00};
        tbl[8]  = '{1'b1, 5'h04, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00};
        tbl[9]  = '{1'b1, 5'h04, 32'h00000000, 4'h5, 32'h0,        2'b00};
        tbl[10] = '{1'b0, 5'h04, 32'h0,        4'h0, 32'hFF00FF00, 2'b00};
        tbl[11] = '{1'b1, 5'h0B, 32'h33,       4'hF, 32'h0,        2'b00};
        tbl[12] = '{1'b0, 5'h08, 32'h0,        4'h0, 32'h33,       2'b00};
        tbl[13] = '{1'b0, 5'h0E, 32'h0,        4'h0, 32'h4,        2'b00};
        tbl[14] = '{1'b1, 5'h14, 32'h55,       4'hF, 32'h0,        OOR_RESP};
        tbl[15] = '{1'b0, 5'h14, 32'h0,        4'h0, OOR_RD,       OOR_RESP};
        tbl[16] = '{1'b0, 5'h04, 32'h0,        4'h0, R1_AFTER,     2'b00};

        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        ARESET = 1'b1;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("reset_outputs",
            {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
             S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, wr_pulse_o}, '0);
        chk("reset_regs", regs_o, '0);
        ARESET = 1'b0;
        tick();
        chk("ready_after_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, rsp);
                mdl_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
                chk($sformatf("tbl%0d_bresp", i), rsp, tbl[i].exp_resp);
            end else begin
                do_read(tbl[i].addr, rd, rsp);
                chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_data);
                chk($sformatf("tbl%0d_rresp", i), rsp, tbl[i].exp_resp);
            end
            if (i == 7)
                chk("regs_after_seq_writes", regs_o,
                    128'h00000004_00000003_00000002_00000001);
        end

        // W three cycles ahead of AW; commit waits for AW, then BREADY is held off.
        S_AXI_BREADY = 1'b0;
        S_AXI_WDATA = 32'hDEADBEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        tick();
        tick();
        chk("w_only_no_commit", {S_AXI_BVALID, wr_pulse_o}, 5'b0);
        S_AXI_AWADDR = 5'h08; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("aw_hs_bvalid_not_yet", {S_AXI_BVALID, wr_pulse_o}, 5'b0);
        tick();
        chk("late_aw_commit", {S_AXI_BVALID, S_AXI_BRESP, wr_pulse_o}, {1'b1, 2'b00, 4'b0100});
        chk("late_aw_reg2", regs_o[95:64], 32'hDEADBEEF);
        mdl_write(5'h08, 32'hDEADBEEF, 4'hF);
        S_AXI_AWADDR = 5'h00; S_AXI_AWVALID = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bstall%0d", c),
                {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, wr_pulse_o}, {3'b100, 4'b0});
        end
        S_AXI_BREADY = 1'b1;
        tick();
        chk("bstall_release", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b01);
        do_write(5'h00, 32'h11, 4'hF, rsp);
        mdl_write(5'h00, 32'h11, 4'hF);
        chk("second_aw_bresp", rsp, 2'b00);
        chk("second_aw_reg0", regs_o[31:0], 32'h11);

        // Read of 0x0 with RREADY low for four cycles.
        S_AXI_ARADDR = 5'h00; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        n = 0;
        while (!S_AXI_ARREADY && n < LIM) begin tick(); n++; end
        if (n >= LIM) timeout("rstall_arready");
        tick();
        S_AXI_ARVALID = 1'b0;
        held = S_AXI_RDATA;
        chk("rstall_first", {S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP}, {1'b1, mdl_read(5'h00), 2'b00});
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("rstall%0d", c), {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP},
                {2'b10, held, 2'b00});
        end
        S_AXI_RREADY = 1'b1;
        tick();
        chk("rstall_release", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b01);

        // Reset while an AW is held without its W.
        S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        chk("midwrite_reset_outputs",
            {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
             S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, wr_pulse_o}, '0);
        chk("midwrite_reset_regs", regs_o, '0);
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        tick();
        S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        tick();
        tick();
        chk("abandoned_aw_no_resp", {S_AXI_BVALID, wr_pulse_o, regs_o}, '0);
        S_AXI_AWADDR = 5'h0C; S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        tick();
        chk("post_reset_commit", {S_AXI_BVALID, wr_pulse_o, regs_o[127:96]}, {1'b1, 4'b1000, 32'h77});
        mdl_write(5'h0C, 32'h77, 4'hF);
        tick();

        // Random traffic against the reference model.
        for (int i = 0; i < 80; i++) begin
            logic [4:0]  a;
            logic [31:0] d;
            logic [3:0]  s;
            a = 5'($urandom_range(0, 31));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, s, rsp);
                mdl_write(a, d, s);
                chk($sformatf("rnd%0d_bresp", i), rsp, oor(a) ? 2'b10 : 2'b00);
            end else begin
                do_read(a, rd, rsp);
                chk($sformatf("rnd%0d_rdata", i), rd, mdl_read(a));
                chk($sformatf("rnd%0d_rresp", i), rsp, oor(a) ? 2'b10 : 2'b00);
            end
        end
        chk("rnd_final_regs", regs_o, {mdl[3], mdl[2], mdl[1], mdl[0]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
